// File: rtl/sliding_window_3x3.sv
// 3x3 sliding-window generator for raster-order video.
// Two line buffers hold the previous two rows; a 3x3 register window shifts
// left one column per accepted pixel and is presented downstream with a
// valid/ready handshake once a full interior neighbourhood is available.
module sliding_window_3x3 #(
  parameter int IMAGE_WIDTH  = 400,
  parameter int IMAGE_HEIGHT = 500,
  parameter int PIXEL_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [PIXEL_W-1:0]              pixel_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [9*PIXEL_W-1:0]            window,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] center_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  center_col,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            done
);

  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [PIXEL_W-1:0]  win_q [9];
  logic [PIXEL_W-1:0]  win_d [9];
  logic                out_valid_q, out_valid_d;
  logic [RW-1:0]       center_row_q, center_row_d;
  logic [CW-1:0]       center_col_q, center_col_d;

  // Row r-2 (top) and row r-1 (middle) at each column; never reset.
  logic [PIXEL_W-1:0]  lb_top [IMAGE_WIDTH];
  logic [PIXEL_W-1:0]  lb_mid [IMAGE_WIDTH];

  logic                accept;
  logic                qualify;
  logic                last_px;
  logic [PIXEL_W-1:0]  top_px;
  logic [PIXEL_W-1:0]  mid_px;

  assign accept  = in_valid && in_ready;
  assign last_px = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // Only interior centres are emitted, so the accept must be at r>=2, c>=2.
  assign qualify = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign top_px  = lb_top[col_q];
  assign mid_px  = lb_mid[col_q];

  // Frame control: next state, input-side ready and end-of-frame pulse.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        // A pending window that is not being taken blocks new input, which
        // keeps the presented window stable.
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (state_q == IDLE && enable) begin
      row_d = '0;
      col_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Window shift: columns move left, new column enters on the right.
  always_comb begin
    for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
    if (accept) begin
      for (int rr = 0; rr < 3; rr++) begin
        win_d[3*rr]     = win_q[3*rr+1];
        win_d[3*rr + 1] = win_q[3*rr+2];
      end
      win_d[2] = top_px;
      win_d[5] = mid_px;
      win_d[8] = pixel_in;
    end
  end

  // Output handshake: a qualifying accept wins over a same-cycle drain.
  always_comb begin
    out_valid_d  = out_valid_q;
    center_row_d = center_row_q;
    center_col_d = center_col_q;
    if (accept && qualify) begin
      out_valid_d  = 1'b1;
      center_row_d = row_q - 1'b1;
      center_col_d = col_q - 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State, counters, window and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      center_row_q <= '0;
      center_col_q <= '0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      center_row_q <= center_row_d;
      center_col_q <= center_col_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
    end
  end

  // Line buffers: column c shifts middle->top and takes the new pixel.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col_q] <= mid_px;
      lb_mid[col_q] <= pixel_in;
    end
  end

  // Pack the window, k = 3*row + col in ascending bit slices.
  always_comb begin
    window = '0;
    for (int k = 0; k < 9; k++) window[k*PIXEL_W +: PIXEL_W] = win_q[k];
  end

  assign out_valid  = out_valid_q;
  assign center_row = center_row_q;
  assign center_col = center_col_q;

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Directed bench for sliding_window_3x3 on a 5x4 frame of pixel = 16*r + c.
module tb_sliding_window_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int NWIN = (H-2)*(W-2);

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [PW-1:0]   pixel_in;
  logic            in_valid;
  logic            in_ready;
  logic [9*PW-1:0] window;
  logic [1:0]      center_row;
  logic [2:0]      center_col;
  logic            out_valid;
  logic            out_ready;
  logic            done;

  int n_chk  = 0;
  int n_pass = 0;

  sliding_window_3x3 #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pixel_in(pixel_in),
    .in_valid(in_valid), .in_ready(in_ready), .window(window),
    .center_row(center_row), .center_col(center_col), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference window for the idx-th interior centre in raster order.
  function automatic logic [9*PW-1:0] exp_win(input int idx);
    logic [9*PW-1:0] w;
    int rr, cc;
    rr = 1 + idx / (W-2);
    cc = 1 + idx % (W-2);
    w = '0;
    for (int k = 0; k < 9; k++)
      w[k*PW +: PW] = 8'(16*(rr-1+k/3) + (cc-1+k%3));
    return w;
  endfunction

  // Stream one frame; returns at a negedge. abort_at>0 stops after that many accepts.
  task automatic run_frame(input bit gap, input bit stall_en, input int en_at, input int abort_at,
                           output bit saw_done);
    int pix = 0, widx = 0, cyc = 0, stall = 0, last_hs = -10;
    bit fin = 0, stalled = 0, lat_pend = 0;
    logic [9*PW-1:0] snap_w;
    logic [4:0] snap_c;
    saw_done = 0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    while (!fin) begin
      if (cyc >= 600) begin
        chk("frame_timeout", 0, 1);
        break;
      end
      enable = (cyc == en_at);
      if (stall_en && out_valid && widx == 0 && !stalled) begin
        stalled = 1; stall = 5; snap_w = window; snap_c = {center_row, center_col};
      end
      out_ready = (stall == 0);
      in_valid  = (pix < W*H) && (gap ? ($urandom_range(0, 1) == 1) : 1'b1);
      pixel_in  = 8'(16*(pix/W) + pix%W);
      #1;
      if (lat_pend) begin
        chk("latency", out_valid, 1);
        lat_pend = 0;
      end
      if (done) begin
        chk("done_wincount", widx, NWIN);
        chk("done_timing", cyc, last_hs + 1);
        chk("done_pixcount", pix, W*H);
        saw_done = 1;
        fin = 1;
      end
      if (out_valid) begin
        if (stall > 0) begin
          chk("stall_window", window, snap_w);
          chk("stall_center", {center_row, center_col}, snap_c);
          chk("stall_in_ready", in_ready, 0);
          stall--;
        end else begin
          if (widx < NWIN) begin
            chk("window", window, exp_win(widx));
            chk("center_row", center_row, 1 + widx/(W-2));
            chk("center_col", center_col, 1 + widx%(W-2));
          end else begin
            chk("extra_window", widx, NWIN - 1);
          end
          widx++;
          last_hs = cyc;
        end
      end
      if (in_valid && in_ready) begin
        if (pix/W >= 2 && pix%W >= 2) lat_pend = 1;
        pix++;
        if (abort_at > 0 && pix == abort_at) fin = 1;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    enable   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_window"}, window, 0);
    chk({tag, "_center"}, {center_row, center_col}, 0);
  endtask

  task automatic frame_and_tail(input bit gap, input bit stall_en, input int en_at, input string tag);
    bit sd;
    run_frame(gap, stall_en, en_at, 0, sd);
    chk({tag, "_done_seen"}, sd, 1);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_ready"}, in_ready, 0);
  endtask

  initial begin
    bit sd;
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; pixel_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 0);

    frame_and_tail(1'b0, 1'b0, -1, "basic");
    frame_and_tail(1'b0, 1'b1, -1, "stall");
    frame_and_tail(1'b1, 1'b0, -1, "gaps");
    frame_and_tail(1'b0, 1'b0, 8,  "enrun");

    // Abort mid-frame, check cleared outputs and absence of done.
    run_frame(1'b0, 1'b0, -1, 10, sd);
    chk("abort_no_done", sd, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_done", done, 0);
      chk("post_reset_valid", out_valid, 0);
    end
    frame_and_tail(1'b0, 1'b0, -1, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
